// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding-request instruction fetch unit.
// One request is in flight at a time. A fetched word is held on
// inst/inst_pc until decode consumes it (stall low), and redirects may
// arrive at any point; a redirect that lands while a request is in
// flight parks the unit in FLUSH so the stale response can drain
// without being presented to decode.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic [63:0] pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] addr_reg, addr_next;
    logic        req_reg, req_next;
    logic [31:0] inst_reg, inst_next;
    logic [63:0] inst_pc_reg, inst_pc_next;
    logic        valid_reg, valid_next;
    logic [31:0] count_reg, count_next;

    // Redirect targets are forced to word alignment; the dropped low
    // bits are deliberately ignored.
    logic [63:0] redirect_target;
    logic [1:0]  unused_redirect_low;

    assign redirect_target     = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_low = redirect_pc[1:0];

    // Next-state and datapath decisions; redirect is always examined first
    // so it wins over ack, stall and consume.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        addr_next    = addr_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        valid_next   = valid_reg;
        count_next   = count_reg;

        case (state_reg)
            IDLE: begin
                // Exactly one cycle here after reset, then start fetching.
                state_next = REQ;
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    addr_next  = redirect_target;
                    valid_next = 1'b0;
                end else begin
                    addr_next = pc_reg;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_ack) begin
                        // Response arrives with the redirect: drop it and
                        // go straight to the new target.
                        addr_next  = redirect_target;
                        state_next = REQ;
                    end else begin
                        // Request still in flight: keep its address on the
                        // bus and wait for it to drain.
                        state_next = FLUSH;
                    end
                end else if (imem_ack) begin
                    inst_next    = imem_rdata;
                    inst_pc_next = addr_reg;
                    valid_next   = 1'b1;
                    pc_next      = pc_reg + 64'd4;
                    state_next   = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    // Held instruction is squashed, not consumed.
                    pc_next    = redirect_target;
                    addr_next  = redirect_target;
                    valid_next = 1'b0;
                    state_next = REQ;
                end else if (!stall) begin
                    valid_next = 1'b0;
                    count_next = count_reg + 32'd1;
                    addr_next  = pc_reg;
                    state_next = REQ;
                end
            end

            FLUSH: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_ack) begin
                        addr_next  = redirect_target;
                        state_next = REQ;
                    end
                end else if (imem_ack) begin
                    // Stale response discarded; refetch from the redirected pc.
                    addr_next  = pc_reg;
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The request line is registered and simply tracks the states that
        // own an outstanding memory access.
        req_next = (state_next == REQ) || (state_next == FLUSH);
    end

    // State register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; reset drops any in-flight request immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_PC;
            addr_reg    <= RESET_PC;
            req_reg     <= 1'b0;
            inst_reg    <= 32'd0;
            inst_pc_reg <= 64'd0;
            valid_reg   <= 1'b0;
            count_reg   <= 32'd0;
        end else begin
            pc_reg      <= pc_next;
            addr_reg    <= addr_next;
            req_reg     <= req_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            valid_reg   <= valid_next;
            count_reg   <= count_next;
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign inst_valid  = valid_reg;
    assign inst        = inst_reg;
    assign inst_pc     = inst_pc_reg;
    assign pc          = pc_reg;
    assign fetch_count = count_reg;

endmodule
